// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard scan-code receiver.
// Conditions the keyboard clock/data lines, assembles 11-bit frames,
// strips break (F0) and extended (E0) prefixes and presents the latest
// make code on tecla_o with a one-cycle valid strobe and an error strobe.
// Optional feature: define PS2_PARITY_CHK_EN to reject frames with bad odd parity.
module ps2_scan_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] tecla_o,
  output logic       tecla_valid_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state, state_nxt;
  logic          ps2_clk_p0, ps2_clk_p1;
  logic          ps2_data_p0, ps2_data_p1;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_clk_d;
  logic          strobe;
  logic [2:0]    bitcnt, bitcnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par_bit, par_bit_nxt;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          brk, brk_nxt;
  logic          ext, ext_nxt;
  logic [7:0]    tecla_nxt;
  logic          valid_nxt, err_nxt;
  logic          frame_ok;

  // Two-flop synchronizers; idle PS/2 lines sit high
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk_i;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_data_p0 <= ps2_data_i;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  // Glitch filter: the filtered clock follows only a level held for FILTER_LEN samples
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      filt_clk_d <= filt_clk;
      if (ps2_clk_p1 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= ps2_clk_p1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign strobe  = filt_clk_d & ~filt_clk;
  assign timeout = (state != S_IDLE) && !strobe && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign busy_o  = (state != S_IDLE);

  // Inter-edge watchdog: counts only inside a frame, restarts on every sample strobe
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt <= '0;
    end else if (state == S_IDLE || strobe || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Frame FSM and prefix decoding; a timeout overrides everything except a strobe
  always_comb begin
    state_nxt   = state;
    bitcnt_nxt  = bitcnt;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    brk_nxt     = brk;
    ext_nxt     = ext;
    tecla_nxt   = tecla_o;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
`ifdef PS2_PARITY_CHK_EN
    frame_ok    = ps2_data_p1 & (^{shreg, par_bit});
`else
    frame_ok    = ps2_data_p1;
`endif
    if (timeout) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
      brk_nxt   = 1'b0;
      ext_nxt   = 1'b0;
    end else if (strobe) begin
      case (state)
        S_IDLE: begin
          if (!ps2_data_p1) begin
            state_nxt  = S_DATA;
            bitcnt_nxt = 3'd0;
          end
        end
        S_DATA: begin
          shreg_nxt = {ps2_data_p1, shreg[7:1]};
          if (bitcnt == 3'd7) state_nxt = S_PARITY;
          else                bitcnt_nxt = bitcnt + 3'd1;
        end
        S_PARITY: begin
          par_bit_nxt = ps2_data_p1;
          state_nxt   = S_STOP;
        end
        S_STOP: begin
          state_nxt = S_IDLE;
          if (!frame_ok) begin
            err_nxt = 1'b1;
          end else if (shreg == 8'hF0) begin
            brk_nxt = 1'b1;
          end else if (shreg == 8'hE0) begin
            ext_nxt = 1'b1;
          end else if (brk) begin
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
          end else begin
            tecla_nxt = shreg;
            valid_nxt = 1'b1;
            ext_nxt   = 1'b0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= S_IDLE;
      bitcnt        <= 3'd0;
      shreg         <= 8'h00;
      par_bit       <= 1'b0;
      brk           <= 1'b0;
      ext           <= 1'b0;
      tecla_o       <= 8'h00;
      tecla_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state         <= state_nxt;
      bitcnt        <= bitcnt_nxt;
      shreg         <= shreg_nxt;
      par_bit       <= par_bit_nxt;
      brk           <= brk_nxt;
      ext           <= ext_nxt;
      tecla_o       <= tecla_nxt;
      tecla_valid_o <= valid_nxt;
      err_o         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_scan_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF_BIT    = 20;
  // drive -> 2 sync flops -> FILTER_LEN filter samples -> registered output
  localparam int LAT         = FILTER_LEN + 3;

  logic       clk_i      = 1'b0;
  logic       rst_i      = 1'b0;
  logic       ps2_clk_i  = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic [7:0] tecla_o;
  logic       tecla_valid_o;
  logic       err_o;
  logic       busy_o;

  ps2_scan_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .tecla_o      (tecla_o),
    .tecla_valid_o(tecla_valid_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_valid = 0, n_err = 0, n_both = 0;
  int valid_cyc = 0, err_cyc = 0, fall_cyc = 0;

  always @(negedge clk_i) begin
    if (tecla_valid_o) begin n_valid++; valid_cyc = cyc; end
    if (err_o) begin n_err++; err_cyc = cyc; end
    if (tecla_valid_o && err_o) n_both++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data_i = b;
    tick(HALF_BIT);
    ps2_clk_i = 1'b0;
    fall_cyc  = cyc;
    tick(HALF_BIT);
    ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
    tick(HALF_BIT);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic send_good(input logic [7:0] d);
    send_frame(d, odd_par(d), 1'b1);
  endtask

  int v0, e0, w;

  initial begin
    // reset state
    tick(4);
    check("rst_tecla", tecla_o, 8'h00);
    check("rst_valid", tecla_valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b1;
    tick(5);

    // 1: plain make code 0x16 (parity 0)
    v0 = n_valid; e0 = n_err;
    send_frame(8'h16, 1'b0, 1'b1);
    check("t1_tecla", tecla_o, 8'h16);
    check("t1_npulse", n_valid - v0, 1);
    check("t1_lat", valid_cyc - fall_cyc, LAT);
    check("t1_noerr", n_err - e0, 0);

    // 2: make 0x45, then break F0 16 leaves 0x45
    send_good(8'h45);
    check("t2_make", tecla_o, 8'h45);
    v0 = n_valid; e0 = n_err;
    send_good(8'hF0);
    send_good(8'h16);
    check("t2_tecla", tecla_o, 8'h45);
    check("t2_nvalid", n_valid - v0, 0);
    check("t2_noerr", n_err - e0, 0);

    // extended make E0 75 updates; extended break E0 F0 75 does not
    v0 = n_valid;
    send_good(8'hE0);
    check("ext_prefix_hold", tecla_o, 8'h45);
    send_good(8'h75);
    check("ext_make", tecla_o, 8'h75);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    check("ext_brk_nvalid", n_valid - v0, 1);

    // typematic repeat of 0x29
    v0 = n_valid;
    send_good(8'h29);
    send_good(8'h29);
    check("typ_tecla", tecla_o, 8'h29);
    check("typ_nvalid", n_valid - v0, 2);

    // bad stop bit
    v0 = n_valid; e0 = n_err;
    send_frame(8'h33, odd_par(8'h33), 1'b0);
    check("stop_err", n_err - e0, 1);
    check("stop_lat", err_cyc - fall_cyc, LAT);
    check("stop_tecla", tecla_o, 8'h29);
    check("stop_nvalid", n_valid - v0, 0);

    // 3: 0x1C with wrong parity bit 1
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHK_EN
    check("t3_err", n_err - e0, 1);
    check("t3_tecla", tecla_o, 8'h29);
    check("t3_nvalid", n_valid - v0, 0);
`else
    check("t3_err", n_err - e0, 0);
    check("t3_tecla", tecla_o, 8'h1C);
    check("t3_nvalid", n_valid - v0, 1);
`endif

    // 4: start + 4 data bits, then the line idles
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    check("t4_busy_mid", busy_o, 1);
    w = 0;
    while (n_err == e0 && w < TIMEOUT_CYC + 200) begin
      tick(1);
      w++;
    end
    check("t4_err", n_err - e0, 1);
    check("t4_lat", err_cyc - fall_cyc, TIMEOUT_CYC + LAT);
    check("t4_busy", busy_o, 0);
    send_good(8'h45);
    check("t4_tecla", tecla_o, 8'h45);

    // 5: 3-cycle low glitch on ps2_clk with data low
    v0 = n_valid; e0 = n_err;
    ps2_data_i = 1'b0;
    tick(5);
    ps2_clk_i = 1'b0;
    tick(3);
    ps2_clk_i = 1'b1;
    tick(30);
    check("t5_busy", busy_o, 0);
    check("t5_events", (n_valid - v0) + (n_err - e0), 0);
    ps2_data_i = 1'b1;
    tick(5);

    // 6: reset after 6 bits of a frame
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    check("t6_busy_pre", busy_o, 1);
    #2;
    rst_i = 1'b0;
    #1;
    check("t6_tecla", tecla_o, 8'h00);
    check("t6_valid", tecla_valid_o, 0);
    check("t6_err", err_o, 0);
    check("t6_busy", busy_o, 0);
    tick(3);
    rst_i = 1'b1;
    tick(5);
    send_good(8'h1E);
    check("t6_after", tecla_o, 8'h1E);

    check("never_both", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
